// File: rtl/demux1_2_2bits_ff_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared constants, lane index type and pointer-width helper for
//           the registered 1:2 demultiplexer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

  // Default data word width
  localparam int DATA_W_DEF = 2;

  // Lane index
  typedef logic lane_t;
  localparam lane_t LANE0 = 1'b0;
  localparam lane_t LANE1 = 1'b1;

  // Pointer width for a FIFO of the given (power-of-two) depth
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux1_2_2bits_ff_if.sv
// ============================================================================
// Module  : demux1_2_2bits_ff_if
// Brief   : Input stream and two output lanes of the 1:2 demultiplexer.
//           Count ports exist only when DEMUX_COUNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux1_2_2bits_ff_if
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W  = 8
`endif
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  lane_t             selector;
  logic              ready_in;

  logic [DATA_W-1:0] data_out0;
  logic              valid_out0;
  logic              ready_out0;

  logic [DATA_W-1:0] data_out1;
  logic              valid_out1;
  logic              ready_out1;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0]  count_out0;
  logic [CNT_W-1:0]  count_out1;
`endif

  // Producer/consumer side
  modport master (
    output data_in, valid_in, selector, ready_out0, ready_out1,
    input  ready_in, data_out0, valid_out0, data_out1, valid_out1
`ifdef DEMUX_COUNT_EN
    ,
    input  count_out0, count_out1
`endif
  );

  // Demultiplexer side
  modport slave (
    input  data_in, valid_in, selector, ready_out0, ready_out1,
    output ready_in, data_out0, valid_out0, data_out1, valid_out1
`ifdef DEMUX_COUNT_EN
    ,
    output count_out0, count_out1
`endif
  );

endinterface

`default_nettype wire

// File: rtl/demux1_2_2bits_ff_lane_fifo.sv
// ============================================================================
// Module  : lane_fifo
// Brief   : Small synchronous FIFO for one demux lane. Power-of-two depth,
//           wrapping pointers and an occupancy counter one bit wider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_occ;
  logic              w_push;
  logic              w_pop;

  assign full      = (r_occ == (PW+1)'(DEPTH));
  assign empty     = (r_occ == '0);
  assign head_data = r_mem[r_rd_ptr];

  // A full lane never takes a word, even when it pops the same cycle
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (PW+1)'(1);
        2'b01:   r_occ <= r_occ - (PW+1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage; contents are masked by empty so it needs no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/demux1_2_2bits_ff.sv
// ============================================================================
// Module  : demux1_2_2bits_ff
// Brief   : Registered 1:2 demultiplexer. Steers accepted words by selector
//           into one of two lane FIFOs with independent backpressure.
//           Optional per-lane delivered-word counters: DEMUX_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1_2_2bits_ff
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic               clk,
  input  logic               reset,
  demux1_2_2bits_ff_if.slave bus
);

  logic [1:0]        w_full;
  logic [1:0]        w_empty;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic [1:0]        w_ready_out;
  logic [DATA_W-1:0] w_head [2];

  // Ready depends only on selector and registered occupancy, never on
  // the downstream ready signals
  assign bus.ready_in = ~reset & ~w_full[bus.selector];

  assign w_ready_out = {bus.ready_out1, bus.ready_out0};

  assign w_push[0] = bus.valid_in & bus.ready_in & (bus.selector == LANE0);
  assign w_push[1] = bus.valid_in & bus.ready_in & (bus.selector == LANE1);
  assign w_pop     = ~w_empty & w_ready_out;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push[l]),
      .push_data (bus.data_in),
      .pop       (w_pop[l]),
      .head_data (w_head[l]),
      .full      (w_full[l]),
      .empty     (w_empty[l])
    );
  end

  assign bus.valid_out0 = ~w_empty[0];
  assign bus.valid_out1 = ~w_empty[1];
  assign bus.data_out0  = w_empty[0] ? '0 : w_head[0];
  assign bus.data_out1  = w_empty[1] ? '0 : w_head[1];

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_count0;
  logic [CNT_W-1:0] r_count1;

  // Delivered-word counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count0 <= '0;
      r_count1 <= '0;
    end else begin
      if (w_pop[0]) r_count0 <= r_count0 + CNT_W'(1);
      if (w_pop[1]) r_count1 <= r_count1 + CNT_W'(1);
    end
  end

  assign bus.count_out0 = r_count0;
  assign bus.count_out1 = r_count1;
`endif

endmodule

`default_nettype wire
